// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, taken-branch flush and
// data-memory wait freeze, with a timeout that latches into a sticky error state.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      INSTR_IF_ID_IN,
  input  logic [31:0]      INSTR_ID_EX_IN,
  input  logic             ID_EX_MEMREAD_IN,
  input  logic             BRANCH_TAKEN_EX_IN,
  input  logic             DMEM_REQ_IN,
  input  logic             DMEM_READY_IN,
  output logic             PC_EN_OUT,
  output logic             IF_ID_EN_OUT,
  output logic             ID_EX_EN_OUT,
  output logic             EX_MEM_EN_OUT,
  output logic             IF_ID_FLUSH_OUT,
  output logic             ID_EX_BUBBLE_OUT,
  output logic             MEM_WB_BUBBLE_OUT,
  output logic [CNT_W-1:0] STALL_CNT_OUT,
  output logic [1:0]       STATE_OUT,
  output logic             ERR_OUT
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  localparam logic [7:0] TIMEOUT_L = TIMEOUT[7:0];

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_waitCnt;
  logic [7:0]       w_nextWaitCnt;
  logic [CNT_W-1:0] r_stallCnt;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic       w_rs1Used;
  logic       w_rs2Used;
  logic       w_loadUse;
  logic       w_memWait;
  logic       w_freeze;
  logic       w_runEvents;
  logic       w_unused;

  assign w_opcode = INSTR_IF_ID_IN[6:0];
  assign w_rs1    = INSTR_IF_ID_IN[19:15];
  assign w_rs2    = INSTR_IF_ID_IN[24:20];
  assign w_rd     = INSTR_ID_EX_IN[11:7];
  assign w_unused = ^{INSTR_IF_ID_IN[31:25], INSTR_IF_ID_IN[14:7],
                      INSTR_ID_EX_IN[31:12], INSTR_ID_EX_IN[6:0]};

  // LUI, AUIPC and JAL carry immediate bits in the rs1 field
  assign w_rs1Used = !((w_opcode == 7'b0110111) || (w_opcode == 7'b0010111) ||
                       (w_opcode == 7'b1101111));
  assign w_rs2Used = (w_opcode == 7'b0110011) || (w_opcode == 7'b0100011) ||
                     (w_opcode == 7'b1100011);

  assign w_loadUse = ID_EX_MEMREAD_IN && (w_rd != 5'd0) &&
                     ((w_rs1Used && (w_rs1 == w_rd)) || (w_rs2Used && (w_rs2 == w_rd)));
  assign w_memWait = DMEM_REQ_IN && !DMEM_READY_IN;

  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_freeze      = 1'b0;
    w_runEvents   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_memWait) begin
          w_freeze      = 1'b1;
          w_nextState   = ST_MEM_WAIT;
          w_nextWaitCnt = 8'd1;
        end else begin
          w_runEvents = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // A ready arriving on the timeout cycle still completes the access
        if (!DMEM_READY_IN) begin
          w_freeze = 1'b1;
          if (r_waitCnt == TIMEOUT_L) begin
            w_nextState = ST_ERROR;
          end else begin
            w_nextWaitCnt = r_waitCnt + 8'd1;
          end
        end else begin
          w_runEvents   = 1'b1;
          w_nextState   = ST_RUN;
          w_nextWaitCnt = 8'd0;
        end
      end
      default: begin
        w_freeze = 1'b1;
      end
    endcase
  end

  always_comb begin
    PC_EN_OUT         = 1'b1;
    IF_ID_EN_OUT      = 1'b1;
    ID_EX_EN_OUT      = 1'b1;
    EX_MEM_EN_OUT     = 1'b1;
    IF_ID_FLUSH_OUT   = 1'b0;
    ID_EX_BUBBLE_OUT  = 1'b0;
    MEM_WB_BUBBLE_OUT = 1'b0;
    if (!RST) begin
      if (w_freeze) begin
        PC_EN_OUT         = 1'b0;
        IF_ID_EN_OUT      = 1'b0;
        ID_EX_EN_OUT      = 1'b0;
        EX_MEM_EN_OUT     = 1'b0;
        MEM_WB_BUBBLE_OUT = 1'b1;
      end else if (w_runEvents && BRANCH_TAKEN_EX_IN) begin
        IF_ID_FLUSH_OUT  = 1'b1;
        ID_EX_BUBBLE_OUT = 1'b1;
      end else if (w_runEvents && w_loadUse) begin
        PC_EN_OUT        = 1'b0;
        IF_ID_EN_OUT     = 1'b0;
        ID_EX_BUBBLE_OUT = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_RUN;
      r_waitCnt  <= 8'd0;
      r_stallCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (!PC_EN_OUT && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
    end
  end

  assign STALL_CNT_OUT = r_stallCnt;
  assign STATE_OUT     = r_state;
  assign ERR_OUT       = (r_state == ST_ERROR) || (r_state == ST_ILLEGAL);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one default instance and one with
// TIMEOUT=4, CNT_W=2 sharing the same stimulus.
module tb_pipe_stall_ctrl;

  localparam logic [6:0] DEF = 7'b1111000;
  localparam logic [6:0] LU  = 7'b0011010;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifId;
  logic [31:0] idEx;
  logic        memRead;
  logic        branch;
  logic        dReq;
  logic        dReady;

  wire  [6:0]  aCtl;
  wire  [15:0] aStall;
  wire  [1:0]  aState;
  wire         aErr;
  wire  [6:0]  bCtl;
  wire  [1:0]  bStall;
  wire  [1:0]  bState;
  wire         bErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dutA (
    .CLK(clk), .RST(rst),
    .INSTR_IF_ID_IN(ifId), .INSTR_ID_EX_IN(idEx),
    .ID_EX_MEMREAD_IN(memRead), .BRANCH_TAKEN_EX_IN(branch),
    .DMEM_REQ_IN(dReq), .DMEM_READY_IN(dReady),
    .PC_EN_OUT(aCtl[6]), .IF_ID_EN_OUT(aCtl[5]), .ID_EX_EN_OUT(aCtl[4]),
    .EX_MEM_EN_OUT(aCtl[3]), .IF_ID_FLUSH_OUT(aCtl[2]),
    .ID_EX_BUBBLE_OUT(aCtl[1]), .MEM_WB_BUBBLE_OUT(aCtl[0]),
    .STALL_CNT_OUT(aStall), .STATE_OUT(aState), .ERR_OUT(aErr)
  );

  pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(2)) dutB (
    .CLK(clk), .RST(rst),
    .INSTR_IF_ID_IN(ifId), .INSTR_ID_EX_IN(idEx),
    .ID_EX_MEMREAD_IN(memRead), .BRANCH_TAKEN_EX_IN(branch),
    .DMEM_REQ_IN(dReq), .DMEM_READY_IN(dReady),
    .PC_EN_OUT(bCtl[6]), .IF_ID_EN_OUT(bCtl[5]), .ID_EX_EN_OUT(bCtl[4]),
    .EX_MEM_EN_OUT(bCtl[3]), .IF_ID_FLUSH_OUT(bCtl[2]),
    .ID_EX_BUBBLE_OUT(bCtl[1]), .MEM_WB_BUBBLE_OUT(bCtl[0]),
    .STALL_CNT_OUT(bStall), .STATE_OUT(bState), .ERR_OUT(bErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a new input vector just after the falling edge, settle briefly
  task automatic applyStimulus(input logic r, input logic [31:0] fi, input logic [31:0] de,
                               input logic mr, input logic br, input logic rq, input logic rd);
    @(negedge clk);
    rst = r; ifId = fi; idEx = de; memRead = mr; branch = br; dReq = rq; dReady = rd;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ifId = NOP; idEx = NOP; memRead = 1'b0;
    branch = 1'b0; dReq = 1'b0; dReady = 1'b0;

    applyStimulus(1, 32'h00028333, 32'h00012283, 1, 1, 1, 0);
    checkOutput("rstCtlA", aCtl, DEF);
    checkOutput("rstCtlB", bCtl, DEF);
    stepEdge();
    checkOutput("rstStateA", aState, 0);
    checkOutput("rstStallA", aStall, 0);
    checkOutput("rstErrA", aErr, 0);

    applyStimulus(0, NOP, NOP, 0, 0, 0, 0);
    checkOutput("idleCtl", aCtl, DEF);
    stepEdge();

    applyStimulus(0, 32'h00028333, 32'h00012283, 1, 0, 0, 0);
    checkOutput("luRs1", aCtl, LU);
    stepEdge();
    checkOutput("luStall1", aStall, 1);

    applyStimulus(0, 32'h00000333, 32'h00012283, 1, 0, 0, 0);
    checkOutput("noUseX0", aCtl, DEF);
    stepEdge();
    applyStimulus(0, 32'h000283B7, 32'h00012283, 1, 0, 0, 0);
    checkOutput("luiNoRs1", aCtl, DEF);
    stepEdge();
    checkOutput("noStallKept", aStall, 1);

    applyStimulus(0, 32'h00502023, 32'h00012283, 1, 0, 0, 0);
    checkOutput("luStoreRs2", aCtl, LU);
    stepEdge();
    checkOutput("luStall2", aStall, 2);

    applyStimulus(0, 32'h00500313, 32'h00012283, 1, 0, 0, 0);
    checkOutput("iTypeNoRs2", aCtl, DEF);
    applyStimulus(0, 32'h00000333, 32'h00002003, 1, 0, 0, 0);
    checkOutput("rdZero", aCtl, DEF);
    applyStimulus(0, 32'h00028333, 32'h00012283, 0, 0, 0, 0);
    checkOutput("noMemRead", aCtl, DEF);

    applyStimulus(0, 32'h00028333, 32'h00012283, 1, 1, 0, 0);
    checkOutput("luBranch", aCtl, BR);
    stepEdge();
    checkOutput("branchNoStall", aStall, 2);
    checkOutput("branchStateRun", aState, 0);

    applyStimulus(1, NOP, NOP, 0, 0, 0, 0);
    stepEdge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, NOP, NOP, 0, (i == 1), 1, 0);
      checkOutput("mwFreeze", aCtl, FRZ);
      checkOutput("mwState", aState, (i == 0) ? 0 : 1);
      stepEdge();
    end
    applyStimulus(0, NOP, NOP, 0, 0, 1, 1);
    checkOutput("mwReleaseCtl", aCtl, DEF);
    checkOutput("mwReleaseState", aState, 1);
    stepEdge();
    checkOutput("mwBackRun", aState, 0);
    checkOutput("mwStall3", aStall, 3);

    applyStimulus(1, NOP, NOP, 0, 0, 0, 0);
    stepEdge();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, NOP, NOP, 0, 0, 1, 0);
      checkOutput("toFreeze", bCtl, FRZ);
      stepEdge();
      checkOutput("toState", bState, (i < 4) ? 1 : 2);
      checkOutput("toErr", bErr, (i == 4) ? 1 : 0);
    end
    checkOutput("stallSat", bStall, 3);
    checkOutput("longWaitA", aState, 1);

    applyStimulus(0, NOP, NOP, 0, 0, 1, 1);
    checkOutput("errFreeze", bCtl, FRZ);
    stepEdge();
    checkOutput("errSticky", bState, 2);
    checkOutput("errStickyOut", bErr, 1);

    applyStimulus(1, NOP, NOP, 0, 0, 1, 0);
    checkOutput("errRstCtl", bCtl, DEF);
    stepEdge();
    checkOutput("errRstState", bState, 0);
    checkOutput("errRstErr", bErr, 0);
    checkOutput("errRstStall", bStall, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, NOP, NOP, 0, 0, 1, 0);
      stepEdge();
    end
    applyStimulus(0, NOP, NOP, 0, 0, 1, 1);
    checkOutput("raceState", bState, 1);
    checkOutput("raceCtl", bCtl, DEF);
    stepEdge();
    checkOutput("raceRun", bState, 0);
    checkOutput("raceNoErr", bErr, 0);
    checkOutput("raceStallSat", bStall, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
